// File: rtl/counters_4_monitor.sv
// counters_4_monitor
//
// Event monitor placed after the four-counter sum stage. It samples the
// 2*SIZE-bit sum bus every cycle and detects:
//   WRAP  (kind 0): sum decreased; payload is the previous sample (the peak).
//   CROSS (kind 1): sum moved from below THRESH to at/above THRESH; payload is the new sum.
//   STALL (kind 2): sum unchanged for STALL_LIM consecutive compares; payload is the sum.
// Detected events are queued in a DEPTH-entry FIFO and drained over valid/ready.
//
// Optional feature: define STALL_DETECT_EN to build the stall counter and STALL
// detection. When undefined, STALL is never produced and STALL_LIM is ignored.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        asynchronous active-low reset
//   en         monitoring enable (detection only; the FIFO always drains)
//   in         sum bus, 2*SIZE bits
//   evt_valid  FIFO non-empty
//   evt_ready  downstream accepts the head entry
//   evt_kind   head event type (0 WRAP, 1 CROSS, 2 STALL), 0 while empty
//   evt_data   head event payload, 0 while empty
//   level      current FIFO occupancy
//   overflow   sticky: an event was dropped because the FIFO was full

module counters_4_monitor #(
  parameter int unsigned SIZE      = 8,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned THRESH    = 200,
  parameter int unsigned STALL_LIM = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [2*SIZE-1:0]      in,
  output logic                   evt_valid,
  input  logic                   evt_ready,
  output logic [1:0]             evt_kind,
  output logic [2*SIZE-1:0]      evt_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow
);

  localparam int unsigned W  = 2 * SIZE;
  localparam int unsigned AW = $clog2(DEPTH);

  localparam logic [W-1:0] ThreshW = W'(THRESH);

  localparam logic [1:0] KindWrap  = 2'd0;
  localparam logic [1:0] KindCross = 2'd1;
`ifdef STALL_DETECT_EN
  localparam logic [1:0] KindStall = 2'd2;
`endif

  // Elaboration-time parameter sanity checks.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two and at least 2");
  end
  if (STALL_LIM < 2) begin : g_bad_stall_lim
    $error("STALL_LIM must be at least 2");
  end

  typedef enum logic [1:0] {
    StIdle,
    StPrime,
    StRun
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   prev_q, prev_d;

  logic           det_valid;
  logic [1:0]     det_kind;
  logic [W-1:0]   det_data;

`ifdef STALL_DETECT_EN
  localparam int unsigned CW = $clog2(STALL_LIM) + 1;
  localparam logic [CW-1:0] StallLast = CW'(STALL_LIM - 1);
  localparam logic [CW-1:0] StallMax  = CW'(STALL_LIM);

  logic [CW-1:0]  stall_cnt_q, stall_cnt_d;
`endif

  // FIFO state: pointers carry one extra wrap bit so full and empty differ.
  logic [AW:0]    wptr_q, wptr_d;
  logic [AW:0]    rptr_q, rptr_d;
  logic           overflow_q, overflow_d;
  logic [1:0]     kind_mem [DEPTH];
  logic [W-1:0]   data_mem [DEPTH];

  logic           fifo_full;
  logic           pop;
  logic           do_push;

  //--------------------------------------------------------------------------
  // Detection FSM
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      prev_q  <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
    end
  end

`ifdef STALL_DETECT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    det_valid = 1'b0;
    det_kind  = KindWrap;
    det_data  = '0;
`ifdef STALL_DETECT_EN
    stall_cnt_d = stall_cnt_q;
`endif

    unique case (state_q)
      StIdle: begin
`ifdef STALL_DETECT_EN
        stall_cnt_d = '0;
`endif
        if (en) begin
          state_d = StPrime;
        end
      end

      // Capture a fresh reference so no compare uses a stale sample.
      StPrime: begin
        prev_d  = in;
        state_d = en ? StRun : StIdle;
`ifdef STALL_DETECT_EN
        stall_cnt_d = '0;
`endif
      end

      StRun: begin
        if (!en) begin
          state_d = StIdle;
        end else begin
          prev_d = in;
          if (in < prev_q) begin
            det_valid = 1'b1;
            det_kind  = KindWrap;
            det_data  = prev_q;
          end else if (prev_q < ThreshW && in >= ThreshW) begin
            det_valid = 1'b1;
            det_kind  = KindCross;
            det_data  = in;
          end
`ifdef STALL_DETECT_EN
          if (in == prev_q) begin
            // Saturate so a long stall fires exactly once.
            if (stall_cnt_q != StallMax) begin
              stall_cnt_d = stall_cnt_q + 1'b1;
            end
            if (stall_cnt_q == StallLast && !det_valid) begin
              det_valid = 1'b1;
              det_kind  = KindStall;
              det_data  = in;
            end
          end else begin
            stall_cnt_d = '0;
          end
`endif
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  //--------------------------------------------------------------------------
  // Event FIFO
  //--------------------------------------------------------------------------
  assign evt_valid = (wptr_q != rptr_q);
  assign level     = wptr_q - rptr_q;
  assign fifo_full = (level == DEPTH[AW:0]);
  assign pop       = evt_valid & evt_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push   = det_valid & (~fifo_full | pop);

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    overflow_d = overflow_q;
    if (do_push) begin
      wptr_d = wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d = rptr_q + 1'b1;
    end
    if (det_valid && fifo_full && !pop) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      kind_mem[wptr_q[AW-1:0]] <= det_kind;
      data_mem[wptr_q[AW-1:0]] <= det_data;
    end
  end

  assign evt_kind = evt_valid ? kind_mem[rptr_q[AW-1:0]] : '0;
  assign evt_data = evt_valid ? data_mem[rptr_q[AW-1:0]] : '0;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_counters_4_monitor.sv
// Self-checking bench for counters_4_monitor: directed scenarios followed by
// randomized traffic, all compared against a queue-based event model.

module tb_counters_4_monitor;

  localparam int unsigned SIZE      = 8;
  localparam int unsigned DEPTH     = 4;
  localparam int unsigned THRESH    = 200;
  localparam int unsigned STALL_LIM = 8;
  localparam int unsigned W         = 2 * SIZE;
  localparam int unsigned LW        = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [W-1:0]  in;
  logic          evt_valid;
  logic          evt_ready;
  logic [1:0]    evt_kind;
  logic [W-1:0]  evt_data;
  logic [LW-1:0] level;
  logic          overflow;

  counters_4_monitor #(
    .SIZE      (SIZE),
    .DEPTH     (DEPTH),
    .THRESH    (THRESH),
    .STALL_LIM (STALL_LIM)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in        (in),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_kind  (evt_kind),
    .evt_data  (evt_data),
    .level     (level),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: phase 0 = disabled, 1 = priming, 2 = comparing.
  typedef struct {
    logic [1:0]   kind;
    logic [W-1:0] data;
  } evt_t;

  evt_t         mq[$];
  int           m_phase;
  logic [W-1:0] m_prev;
  int           m_same;
  bit           m_ovf;
  logic [W-1:0] last_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_phase = 0;
    m_prev  = '0;
    m_same  = 0;
    m_ovf   = 1'b0;
  endtask

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_step();
    bit   has;
    bit   do_pop;
    evt_t ev;
    has    = 1'b0;
    ev     = '{kind: 2'd0, data: '0};
    do_pop = (mq.size() != 0) && evt_ready;
    case (m_phase)
      0: begin
        m_same = 0;
        if (en) m_phase = 1;
      end
      1: begin
        m_prev  = in;
        m_same  = 0;
        m_phase = en ? 2 : 0;
      end
      default: begin
        if (!en) begin
          m_phase = 0;
        end else begin
          if (in < m_prev) begin
            has = 1'b1;
            ev  = '{kind: 2'd0, data: m_prev};
          end else if (m_prev < THRESH && in >= THRESH) begin
            has = 1'b1;
            ev  = '{kind: 2'd1, data: in};
          end
          if (in == m_prev) m_same++;
          else m_same = 0;
`ifdef STALL_DETECT_EN
          if (m_same == STALL_LIM && !has) begin
            has = 1'b1;
            ev  = '{kind: 2'd2, data: in};
          end
`endif
          m_prev = in;
        end
      end
    endcase
    if (do_pop) void'(mq.pop_front());
    if (has) begin
      if (mq.size() < DEPTH) mq.push_back(ev);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [1:0]   ek;
    logic [W-1:0] ed;
    ek = (mq.size() != 0) ? mq[0].kind : 2'd0;
    ed = (mq.size() != 0) ? mq[0].data : '0;
    check({tag, ".valid"},    32'(evt_valid), 32'(mq.size() != 0));
    check({tag, ".level"},    32'(level),     32'(mq.size()));
    check({tag, ".overflow"}, 32'(overflow),  32'(m_ovf));
    check({tag, ".kind"},     32'(evt_kind),  32'(ek));
    check({tag, ".data"},     32'(evt_data),  32'(ed));
  endtask

  // Called just after an active edge; drives inputs, clocks once, checks.
  task automatic cycle(input string tag, input logic e, input logic [W-1:0] v, input logic r);
    en        = e;
    in        = v;
    evt_ready = r;
    last_in   = v;
    model_step();
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  initial begin
    rst       = 1'b0;
    en        = 1'b0;
    in        = '0;
    evt_ready = 1'b0;
    last_in   = '0;
    model_reset();
    #1;
    check_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Rising sum: no events.
    for (int i = 0; i < 3; i++) cycle("ramp", 1'b1, W'(10 + i), 1'b1);

    // Wrap 250 -> 5; event visible right after the edge that samples 5.
    cycle("pre_wrap", 1'b1, W'(250), 1'b1);
    cycle("wrap", 1'b1, W'(5), 1'b1);
    check("wrap_latency", 32'(evt_valid), 32'd1);
    check("wrap_payload", 32'(evt_data), 32'd250);
    cycle("wrap_drain", 1'b1, W'(6), 1'b1);

    // Threshold crossings and a direct 255 -> 0 wrap.
    begin
      int seq [6] = '{199, 200, 150, 255, 0, 1};
      foreach (seq[i]) cycle("cross", 1'b1, W'(seq[i]), 1'b1);
    end

    // Six wraps while stalled downstream: fill then overflow.
    for (int i = 0; i < 6; i++) begin
      cycle("fill_hi", 1'b1, W'(100), 1'b0);
      cycle("fill_lo", 1'b1, W'(50), 1'b0);
    end
    check("full_level", 32'(level), 32'(DEPTH));
    check("full_ovf", 32'(overflow), 32'd1);
    for (int i = 0; i < 6; i++) cycle("drain", 1'b1, W'(60 + i), 1'b1);

    // Held sum: a single STALL only when the feature is built.
    for (int i = 0; i < 20; i++) cycle("stall", 1'b1, W'(77), 1'b1);
    for (int i = 0; i < 3; i++) cycle("stall_after", 1'b1, W'(78 + i), 1'b1);

    // Queue three entries, then reset mid-drain.
    for (int i = 0; i < 3; i++) begin
      cycle("q_hi", 1'b1, W'(120), 1'b0);
      cycle("q_lo", 1'b1, W'(30), 1'b0);
    end
    cycle("q_drain", 1'b1, W'(31), 1'b1);
    rst = 1'b0;
    #1;
    model_reset();
    check("async_rst_valid", 32'(evt_valid), 32'd0);
    check("async_rst_level", 32'(level), 32'd0);
    check_outputs("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b1;
    cycle("reen_idle", 1'b1, W'(500), 1'b1);
    cycle("reen_prime", 1'b1, W'(3), 1'b1);
    cycle("reen_run", 1'b1, W'(4), 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [W-1:0] v;
      logic         e;
      logic         r;
      case ($urandom_range(0, 3))
        0:       v = W'($urandom);
        1:       v = last_in;
        2:       v = last_in + W'($urandom_range(1, 3));
        default: v = W'($urandom_range(THRESH - 12, THRESH + 12));
      endcase
      e = ($urandom_range(0, 15) != 0);
      r = ($urandom_range(0, 3) != 0);
      cycle("rand", e, v, r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
